// File: rtl/sblock_cfg_loader.sv
// Serial configuration loader for a row of switch blocks: shifts in one 18-bit
// frame per tile, then pulses that tile's latch enable with the frame held stable.
module sblock_cfg_loader #(
    parameter int NUM_TILES = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [NUM_TILES-1:0] wr_en,
    output logic [17:0]          bits,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_SETUP = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [17:0]    shreg_q, shreg_d;
    logic [17:0]    bits_q, bits_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  tile_q, tile_d;
    logic [3:0]     wr_cnt_q, wr_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bits_q    <= '0;
            bit_cnt_q <= '0;
            tile_q    <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bits_q    <= bits_d;
            bit_cnt_q <= bit_cnt_d;
            tile_q    <= tile_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bits_d    = bits_q;
        bit_cnt_d = bit_cnt_q;
        tile_d    = tile_q;
        wr_cnt_d  = wr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SHIFT;
                    tile_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    shreg_d = {shreg_q[16:0], bit_in};
                    if (bit_cnt_q == 5'd17) begin
                        // Capture the completed frame as SETUP is entered so the
                        // output is already valid during SETUP.
                        bits_d    = {shreg_q[16:0], bit_in};
                        bit_cnt_d = '0;
                        state_d   = S_SETUP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_SETUP: begin
                wr_cnt_d = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (wr_cnt_q == 4'(WR_CYCLES - 1)) begin
                    state_d = S_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (tile_q == TW'(NUM_TILES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    tile_d  = tile_q + TW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bit_ready = (state_q == S_SHIFT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign bits      = bits_q;

    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_wr
        assign wr_en[gi] = (state_q == S_WRITE) && (tile_q == TW'(gi));
    end

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Bench for sblock_cfg_loader: a per-cycle expectation timeline is built from
// the load protocol (frames, stalls, phase lengths) and replayed against the DUT.
module tb_sblock_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;

    logic        a_ready, a_busy, a_done;
    logic [3:0]  a_wr;
    logic [17:0] a_bits;
    logic        b_ready, b_busy, b_done;
    logic [0:0]  b_wr;
    logic [17:0] b_bits;

    int vectors = 0;
    int miscompares = 0;
    int load_no = 0;

    logic [17:0] frame_m [4];

    typedef struct packed {
        logic        start;
        logic        valid;
        logic        bitin;
        logic        rdy;
        logic [3:0]  wr;
        logic        busy;
        logic        done;
        logic        chk_bits;
        logic [17:0] bits;
    } step_t;

    step_t sched[$];

    sblock_cfg_loader #(.NUM_TILES(4), .WR_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(a_ready), .wr_en(a_wr), .bits(a_bits), .busy(a_busy), .done(a_done)
    );

    sblock_cfg_loader #(.NUM_TILES(1), .WR_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(b_ready), .wr_en(b_wr), .bits(b_bits), .busy(b_busy), .done(b_done)
    );

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push_step(logic st, logic v, logic bi, logic rdy, logic [3:0] wr,
                                      logic bsy, logic dn, logic cb, logic [17:0] bt);
        step_t s;
        s.start = st; s.valid = v; s.bitin = bi; s.rdy = rdy; s.wr = wr;
        s.busy = bsy; s.done = dn; s.chk_bits = cb; s.bits = bt;
        sched.push_back(s);
    endfunction

    // Timeline of one load: start cycle, per tile 18 transfers (plus stalls),
    // SETUP, WR cycles of WRITE, HOLD; then DONE and a return to IDLE.
    task automatic build_load(input int nt, input int wrc, input bit rand_stall,
                              input int stall_bit, input int stall_len, input bit poke);
        sched.delete();
        push_step(1'b1, rnd(), rnd(), 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 18'h0);
        for (int t = 0; t < nt; t++) begin
            for (int b = 0; b < 18; b++) begin
                int ns;
                ns = 0;
                if (rand_stall && $urandom_range(0, 3) == 0) ns = int'($urandom_range(1, 3));
                if (t == 0 && b == stall_bit) ns = stall_len;
                for (int s = 0; s < ns; s++)
                    push_step(1'b0, 1'b0, rnd(), 1'b1, 4'b0, 1'b1, 1'b0, 1'b0, 18'h0);
                push_step(poke && t == nt - 1 && b == 5, 1'b1, frame_m[t][17 - b],
                          1'b1, 4'b0, 1'b1, 1'b0, 1'b0, 18'h0);
            end
            push_step(1'b0, rnd(), rnd(), 1'b0, 4'b0, 1'b1, 1'b0, 1'b1, frame_m[t]);
            for (int w = 0; w < wrc; w++)
                push_step(1'b0, rnd(), rnd(), 1'b0, 4'(1 << t), 1'b1, 1'b0, 1'b1, frame_m[t]);
            push_step(1'b0, rnd(), rnd(), 1'b0, 4'b0, 1'b1, 1'b0, 1'b1, frame_m[t]);
        end
        push_step(poke, rnd(), rnd(), 1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 18'h0);
        push_step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 18'h0);
    endtask

    task automatic run_sched(input bit sel, input int abort_at, output int done_cycle);
        logic [6:0]  obs, exp;
        logic [17:0] obs_bits, prev_bits;
        logic [3:0]  obs_wr, prev_wr;
        done_cycle = -1;
        prev_wr = 4'b0;
        prev_bits = 18'h0;
        for (int i = 0; i < sched.size(); i++) begin
            @(negedge clk);
            if (sel) begin
                obs_wr = {3'b000, b_wr};
                obs = {b_ready, obs_wr, b_busy, b_done};
                obs_bits = b_bits;
            end else begin
                obs_wr = a_wr;
                obs = {a_ready, obs_wr, a_busy, a_done};
                obs_bits = a_bits;
            end
            exp = {sched[i].rdy, sched[i].wr, sched[i].busy, sched[i].done};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ctrl load%0d cyc%0d: rdy/wr/busy/done got %b required %b",
                         load_no, i, obs, exp);
            end
            if (sched[i].chk_bits) begin
                vectors++;
                if (obs_bits !== sched[i].bits) begin
                    miscompares++;
                    $display("FAIL bits load%0d cyc%0d: got %05h required %05h",
                             load_no, i, obs_bits, sched[i].bits);
                end
            end
            if (obs_wr != 4'b0) begin
                vectors++;
                if (!$onehot(obs_wr) || (prev_wr != 4'b0 && obs_bits !== prev_bits)) begin
                    miscompares++;
                    $display("FAIL wr_onehot_stable load%0d cyc%0d: wr %b bits %05h prev %05h required onehot and stable",
                             load_no, i, obs_wr, obs_bits, prev_bits);
                end
            end
            prev_wr = obs_wr;
            prev_bits = obs_bits;
            if (obs[0] === 1'b1 && done_cycle < 0) done_cycle = i;
            if (i == abort_at) begin
                rst = 1'b1;
                start = 1'b0;
                bit_valid = 1'b0;
                break;
            end
            start = sched[i].start;
            bit_valid = sched[i].valid;
            bit_in = sched[i].bitin;
        end
        start = 1'b0;
        bit_valid = 1'b0;
        $display("load %0d: dut=%s frames %05h %05h %05h %05h done at cycle %0d",
                 load_no, sel ? "B" : "A", frame_m[0], frame_m[1], frame_m[2], frame_m[3], done_cycle);
        load_no++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_frames();
        for (int k = 0; k < 4; k++) frame_m[k] = 18'($urandom);
    endtask

    task automatic check_done(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: done cycle %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        vectors++;
        if ({a_ready, a_wr, a_busy, a_done, a_bits} !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_a: got %b required all zero", {a_ready, a_wr, a_busy, a_done, a_bits});
        end
        vectors++;
        if ({b_ready, b_wr, b_busy, b_done, b_bits} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_b: got %b required all zero", {b_ready, b_wr, b_busy, b_done, b_bits});
        end
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic test_directed_frames();
        int dc;
        do_reset();
        frame_m[0] = 18'h3FFFF; frame_m[1] = 18'h00000;
        frame_m[2] = 18'h2AAAA; frame_m[3] = 18'h15555;
        build_load(4, 2, 1'b0, -1, 0, 1'b0);
        run_sched(1'b0, -1, dc);
        check_done("done_latency_4x2", dc, 1 + 4 * (18 + 2 + 2));
    endtask

    task automatic test_stall();
        int dc;
        do_reset();
        rand_frames();
        frame_m[0] = 18'h20001;
        build_load(4, 2, 1'b0, 8, 5, 1'b0);
        run_sched(1'b0, -1, dc);
        check_done("done_latency_stall5", dc, 1 + 4 * (18 + 2 + 2) + 5);
    endtask

    task automatic test_start_ignored();
        int dc;
        do_reset();
        rand_frames();
        build_load(4, 2, 1'b0, -1, 0, 1'b1);
        run_sched(1'b0, -1, dc);
        check_done("done_latency_start_poke", dc, 1 + 4 * (18 + 2 + 2));
    endtask

    task automatic test_reset_mid_write();
        int dc;
        do_reset();
        rand_frames();
        build_load(4, 2, 1'b0, -1, 0, 1'b0);
        // second WRITE cycle of tile 2: after start, two full tiles, 18 shifts, SETUP, WRITE
        run_sched(1'b0, 1 + 2 * (18 + 2 + 2) + 18 + 1 + 1, dc);
        @(negedge clk);
        vectors++;
        if ({a_wr, a_bits, a_busy, a_ready, a_done} !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_in_write: wr %b bits %05h busy %b rdy %b done %b required all zero",
                     a_wr, a_bits, a_busy, a_ready, a_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit_valid = rnd();
            @(negedge clk);
            vectors++;
            if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL no_resume cyc%0d: busy %b rdy %b required 0 0", k, a_busy, a_ready);
            end
        end
        bit_valid = 1'b0;
        rand_frames();
        build_load(4, 2, 1'b0, -1, 0, 1'b0);
        run_sched(1'b0, -1, dc);
        check_done("done_latency_after_reset", dc, 1 + 4 * (18 + 2 + 2));
    endtask

    task automatic test_single_tile();
        int dc;
        do_reset();
        rand_frames();
        frame_m[0] = 18'h1FF00;
        build_load(1, 1, 1'b0, -1, 0, 1'b0);
        run_sched(1'b1, -1, dc);
        check_done("done_latency_1x1", dc, 1 + 1 * (18 + 1 + 2));
        vectors++;
        if (b_bits[17:9] !== 9'h0FF || b_bits[8:0] !== 9'h100) begin
            miscompares++;
            $display("FAIL bits_split_1x1: got h=%03h v=%03h required h=0ff v=100",
                     b_bits[17:9], b_bits[8:0]);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            rand_frames();
            build_load(4, 2, 1'b1, -1, 0, n == 1);
            run_sched(1'b0, -1, dc);
            check_done("done_seen_random", int'(dc == sched.size() - 2), 1);
        end
        rand_frames();
        build_load(1, 1, 1'b1, -1, 0, 1'b1);
        run_sched(1'b1, -1, dc);
        check_done("done_seen_random_b", int'(dc == sched.size() - 2), 1);
    endtask

    initial begin
        test_reset();
        test_directed_frames();
        test_stall();
        test_start_ignored();
        test_reset_mid_write();
        test_single_tile();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
